mov_bus_sequencer: RTL

//  Sequences MOV transfers between the 74173-style registers that share the tri-state data bus.

---
 rtl/mov_bus_sequencer_pkg.sv | 12 +
 rtl/mov_bus_sequencer_if.sv | 19 +
 rtl/mov_bus_sequencer_req_buf.sv | 29 ++
 rtl/mov_bus_sequencer.sv | 104 ++++++++++
 4 files changed

// File: rtl/mov_bus_sequencer_pkg.sv
// mov_bus_pkg: shared FSM states, request struct and default sizes for the MOV bus sequencer.
package mov_bus_pkg;
    localparam int NREGS_DEF = 4;
    localparam int IDX_W_DEF = 2;
    localparam int IDX_W_MAX = 8;
    typedef enum logic [2:0] {IDLE, DRIVE, LOAD, HOLD, ERR} state_e;
    // Indices are zero-extended to IDX_W_MAX so one struct serves every IDX_W.
    typedef struct packed {
        logic [IDX_W_MAX-1:0] src;
        logic [IDX_W_MAX-1:0] dst;
    } mov_req_t;
endpackage

// File: rtl/mov_bus_sequencer_if.sv
// mov_bus_sequencer_if: MOV request handshake plus per-register bus output/load enables.
interface mov_bus_sequencer_if
    import mov_bus_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int IDX_W = IDX_W_DEF
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_src;
    logic [IDX_W-1:0] req_dst;
    logic             busy;
    logic             done;
    logic             err;
    logic [NREGS-1:0] oe;
    logic [NREGS-1:0] load_n;
    modport master (output req_valid, req_src, req_dst, input req_ready, busy, done, err, oe, load_n);
    modport slave (input req_valid, req_src, req_dst, output req_ready, busy, done, err, oe, load_n);
endinterface

// File: rtl/mov_bus_sequencer_req_buf.sv
// mov_req_buf: one-entry pending MOV request register; only built when MOV_PENDING_EN is defined.
`ifdef MOV_PENDING_EN
module mov_req_buf
    import mov_bus_pkg::*;
(
    input  logic     clk,
    input  logic     clr,
    input  logic     push_i,
    input  logic     pop_i,
    input  mov_req_t data_i,
    output logic     valid_o,
    output logic     ready_o,
    output mov_req_t data_o
);
    logic valid_d;
    assign valid_d = push_i || (valid_o && !pop_i);
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            data_o  <= '0;
        end else begin
            valid_o <= valid_d;
            ready_o <= !valid_d;
            if (push_i) data_o <= data_i;
        end
    end
endmodule
`endif

// File: rtl/mov_bus_sequencer.sv
// mov_bus_sequencer: drives one source OE then one active-low load per MOV on a shared register bus.
// Define MOV_PENDING_EN to add a one-entry pending buffer so transfers run back-to-back.
module mov_bus_sequencer
    import mov_bus_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic clr,
    mov_bus_sequencer_if.slave bus
);
    localparam int CW = $clog2(SETTLE + 1);
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mov_req_t         cur_q, cur_d, in_req, nxt_req;
    logic [NREGS-1:0] oe_q, oe_d, load_n_q, load_n_d, src_hot, dst_hot;
    logic             done_q, err_q, busy_q, ready_q;
    logic             accept, finishing, have, nxt_ok;

    assign in_req    = '{src: IDX_W_MAX'(bus.req_src), dst: IDX_W_MAX'(bus.req_dst)};
    assign accept    = bus.req_valid && ready_q;
    assign finishing = state_q inside {IDLE, HOLD, ERR};
    assign nxt_ok    = nxt_req.src != nxt_req.dst && nxt_req.src < IDX_W_MAX'(NREGS)
                       && nxt_req.dst < IDX_W_MAX'(NREGS);

`ifdef MOV_PENDING_EN
    mov_req_t pend_req;
    logic     pend_valid, pop, push;
    // A request arriving with the slot empty while finishing goes straight to the FSM.
    assign pop     = finishing && pend_valid;
    assign push    = accept && !(finishing && !pend_valid);
    assign have    = pend_valid || accept;
    assign nxt_req = pend_valid ? pend_req : in_req;
    mov_req_buf u_buf (
        .clk     (clk),
        .clr     (clr),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_req),
        .valid_o (pend_valid),
        .ready_o (ready_q),
        .data_o  (pend_req)
    );
`else
    assign have    = accept;
    assign nxt_req = in_req;
    always_ff @(posedge clk) ready_q <= clr || state_d == IDLE;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        if (finishing) begin
            state_d = !have ? IDLE : nxt_ok ? DRIVE : ERR;
            cur_d   = have ? nxt_req : cur_q;
            cnt_d   = CW'(SETTLE - 1);
        end else if (state_q == DRIVE) begin
            state_d = cnt_q == '0 ? LOAD : DRIVE;
            cnt_d   = cnt_q - 1'b1;
        end else begin
            state_d = HOLD;
        end
        src_hot = '0;
        dst_hot = '0;
        for (int i = 0; i < NREGS; i++) begin
            src_hot[i] = cur_d.src == IDX_W_MAX'(i);
            dst_hot[i] = cur_d.dst == IDX_W_MAX'(i);
        end
        oe_d     = (state_d inside {DRIVE, LOAD, HOLD}) ? src_hot : '0;
        load_n_d = (state_d == LOAD) ? ~dst_hot : '1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cur_q    <= '0;
            oe_q     <= '0;
            load_n_q <= '1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
            oe_q     <= oe_d;
            load_n_q <= load_n_d;
            done_q   <= state_d == HOLD;
            err_q    <= state_d == ERR;
            busy_q   <= state_d != IDLE;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.oe        = oe_q;
    assign bus.load_n    = load_n_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
endmodule
